tlb_set_assoc: RTL and testbench

TLB_SET_ASSOC -- requirements
Module: tlb_set_assoc

---
 rtl/config_pkg.sv | 17 +
 rtl/tlbplru.sv | 50 +++++
 rtl/tlb_set_assoc.sv | 202 ++++++++++++++++++++
 tb/tb_tlb_set_assoc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared TLB types: the stored translation entry and the flush FSM states.
package config_pkg;
  localparam int TLB_VPN_W  = 27;
  localparam int TLB_PPN_W  = 44;
  localparam int TLB_ASID_W = 16;
  localparam int PERM_G     = 5;   // DAGUXWRV: G is bit 5

  typedef struct packed {
    logic                  valid;
    logic [TLB_VPN_W-1:0]  vpn;
    logic [TLB_ASID_W-1:0] asid;
    logic [TLB_PPN_W-1:0]  ppn;
    logic [7:0]            perm;
  } tlb_entry_t;

  typedef enum logic [1:0] {FL_IDLE, FL_SINGLE, FL_WALK} flush_state_e;
endpackage

// File: rtl/tlbplru.sv
// Tree pseudo-LRU for one set. Two touches per cycle are applied in order:
// access 0 first, then access 1, so access 1 has the final say on shared nodes.
module tlbplru #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            access_valid,
  input  logic [1:0][WAY_W-1:0] access_way,
  output logic [WAY_W-1:0]      victim_way
);
  logic [WAYS-2:0] tree_q, tree_nxt;

  // Heap-ordered nodes (root = 1, stored at node-1); a node bit points at the
  // half that was NOT touched last, i.e. towards the victim.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t,
                                            input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r;
    int node;
    r    = t;
    node = 1;
    for (int l = WAY_W-1; l >= 0; l--) begin
      r[node-1] = ~w[l];
      node      = 2*node + int'(w[l]);
    end
    return r;
  endfunction

  always_comb begin
    tree_nxt = tree_q;
    if (access_valid[0]) tree_nxt = touch(tree_nxt, access_way[0]);
    if (access_valid[1]) tree_nxt = touch(tree_nxt, access_way[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) tree_q <= '0;
    else       tree_q <= tree_nxt;
  end

  always_comb begin
    int node;
    node       = 1;
    victim_way = '0;
    for (int l = WAY_W-1; l >= 0; l--) begin
      victim_way[l] = tree_q[node-1];
      node          = 2*node + int'(tree_q[node-1]);
    end
  end
endmodule

// File: rtl/tlb_set_assoc.sv
// Set-associative 4 KiB TLB with one-cycle registered lookup, write-with-dedup,
// per-set tree PLRU replacement and a single-VA / full-walk flush engine.
module tlb_set_assoc
  import config_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int VPN_W  = 27,
  parameter int PPN_W  = 44,
  parameter int ASID_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LookupValid,
  input  logic [VPN_W-1:0]  LookupVPN,
  input  logic [ASID_W-1:0] LookupASID,
  output logic              RespValid,
  output logic              RespHit,
  output logic [PPN_W-1:0]  RespPPN,
  output logic [7:0]        RespPerm,
  input  logic              TLBWrite,
  input  logic [VPN_W-1:0]  WriteVPN,
  input  logic [ASID_W-1:0] WriteASID,
  input  logic [PPN_W-1:0]  WritePPN,
  input  logic [7:0]        WritePerm,
  input  logic              FlushReq,
  input  logic              FlushVAValid,
  input  logic [VPN_W-1:0]  FlushVPN,
  input  logic              FlushASIDValid,
  input  logic [ASID_W-1:0] FlushASID,
  output logic              FlushBusy,
  output logic              FlushDone
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  tlb_entry_t   mem [SETS][WAYS];
  flush_state_e state_q;
  logic [SET_W-1:0]  cnt_q;
  logic              busy_q, done_q;
  logic [VPN_W-1:0]  f_vpn_q;
  logic              f_asid_v_q;
  logic [ASID_W-1:0] f_asid_q;

  logic              resp_valid_q, resp_hit_q;
  logic [PPN_W-1:0]  resp_ppn_q;
  logic [7:0]        resp_perm_q;

  function automatic logic entry_hit(input tlb_entry_t e, input logic [VPN_W-1:0] vpn,
                                     input logic [ASID_W-1:0] asid);
    return e.valid && (e.vpn == TLB_VPN_W'(vpn)) &&
           ((e.asid == TLB_ASID_W'(asid)) || e.perm[PERM_G]);
  endfunction

  function automatic logic [WAY_W-1:0] first_one(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int w = WAYS-1; w >= 0; w--) if (v[w]) r = WAY_W'(w);
    return r;
  endfunction

  // Lookup path
  logic [SET_W-1:0] lu_set;
  logic [WAYS-1:0]  lu_hit_vec;
  logic [WAY_W-1:0] lu_way;
  logic             lu_en;

  assign lu_set = LookupVPN[SET_W-1:0];
  always_comb begin
    lu_hit_vec = '0;
    for (int w = 0; w < WAYS; w++) lu_hit_vec[w] = entry_hit(mem[lu_set][w], LookupVPN, LookupASID);
  end
  assign lu_way = first_one(lu_hit_vec);
  assign lu_en  = LookupValid && (|lu_hit_vec) && !busy_q;

  // Write path: existing match, else lowest free way, else PLRU victim
  logic [SET_W-1:0]            wr_set;
  logic [WAYS-1:0]             wr_match, wr_free;
  logic [WAY_W-1:0]            wr_way;
  logic                        wr_en;
  logic [SETS-1:0][WAY_W-1:0]  victim_vec;

  assign wr_set = WriteVPN[SET_W-1:0];
  always_comb begin
    wr_match = '0;
    wr_free  = '0;
    for (int w = 0; w < WAYS; w++) begin
      // a global write also replaces a same-VPN entry of another ASID
      wr_match[w] = entry_hit(mem[wr_set][w], WriteVPN, WriteASID) ||
                    (mem[wr_set][w].valid && (mem[wr_set][w].vpn == TLB_VPN_W'(WriteVPN)) &&
                     WritePerm[PERM_G]);
      wr_free[w]  = !mem[wr_set][w].valid;
    end
  end
  assign wr_way = (|wr_match) ? first_one(wr_match) :
                  (|wr_free)  ? first_one(wr_free)  : victim_vec[wr_set];
  assign wr_en  = TLBWrite && !busy_q;

  for (genvar s = 0; s < SETS; s++) begin : g_plru
    tlbplru #(.WAYS(WAYS)) u_plru (
      .clk          (clk),
      .reset        (reset),
      .access_valid ({wr_en && (wr_set == SET_W'(s)), lu_en && (lu_set == SET_W'(s))}),
      .access_way   ({wr_way, lu_way}),
      .victim_way   (victim_vec[s])
    );
  end

  // Flush kill vector for the set currently being processed
  logic [SET_W-1:0] fl_set;
  logic [WAYS-1:0]  fl_kill;

  assign fl_set = (state_q == FL_SINGLE) ? f_vpn_q[SET_W-1:0] : cnt_q;
  always_comb begin
    fl_kill = '0;
    for (int w = 0; w < WAYS; w++)
      fl_kill[w] = mem[fl_set][w].valid &&
                   ((state_q != FL_SINGLE) || (mem[fl_set][w].vpn == TLB_VPN_W'(f_vpn_q))) &&
                   (!f_asid_v_q || (!mem[fl_set][w].perm[PERM_G] &&
                                    (mem[fl_set][w].asid == TLB_ASID_W'(f_asid_q))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mem[s][w].valid <= 1'b0;
    end else begin
      if (wr_en)
        mem[wr_set][wr_way] <= '{valid: 1'b1, vpn: TLB_VPN_W'(WriteVPN),
                                 asid: TLB_ASID_W'(WriteASID), ppn: TLB_PPN_W'(WritePPN),
                                 perm: WritePerm};
      if (busy_q)
        for (int w = 0; w < WAYS; w++) if (fl_kill[w]) mem[fl_set][w].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FL_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      f_vpn_q    <= '0;
      f_asid_v_q <= 1'b0;
      f_asid_q   <= '0;
    end else begin
      case (state_q)
        FL_IDLE: if (FlushReq) begin
          f_vpn_q    <= FlushVPN;
          f_asid_v_q <= FlushASIDValid;
          f_asid_q   <= FlushASID;
          busy_q     <= 1'b1;
          cnt_q      <= '0;
          state_q    <= FlushVAValid ? FL_SINGLE : FL_WALK;
          done_q     <= FlushVAValid;
        end
        FL_SINGLE: begin
          state_q <= FL_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        FL_WALK: begin
          if (cnt_q == SET_W'(SETS-1)) begin
            state_q <= FL_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == SET_W'(SETS-2));
          end
        end
        default: begin
          state_q <= FL_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_perm_q  <= '0;
    end else begin
      resp_valid_q <= LookupValid;
      resp_hit_q   <= lu_en;
      resp_ppn_q   <= lu_en ? PPN_W'(mem[lu_set][lu_way].ppn) : '0;
      resp_perm_q  <= lu_en ? mem[lu_set][lu_way].perm : '0;
    end
  end

  assign FlushBusy = busy_q;
  assign FlushDone = done_q;
  assign RespValid = resp_valid_q;
  assign RespHit   = resp_hit_q && !busy_q;
  assign RespPPN   = RespHit ? resp_ppn_q : '0;
  assign RespPerm  = RespHit ? resp_perm_q : '0;
endmodule

// File: tb/tb_tlb_set_assoc.sv
// Directed bench for tlb_set_assoc: a per-cycle timestamp/array model checks
// every output, and literal expectations pin the key scenarios.
module tb_tlb_set_assoc;
  localparam int SETS = 16, WAYS = 4, VPN_W = 27, PPN_W = 44, ASID_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              LookupValid, TLBWrite, FlushReq, FlushVAValid, FlushASIDValid;
  logic [VPN_W-1:0]  LookupVPN, WriteVPN, FlushVPN;
  logic [ASID_W-1:0] LookupASID, WriteASID, FlushASID;
  logic [PPN_W-1:0]  WritePPN;
  logic [7:0]        WritePerm;
  logic              RespValid, RespHit, FlushBusy, FlushDone;
  logic [PPN_W-1:0]  RespPPN;
  logic [7:0]        RespPerm;

  tlb_set_assoc #(.SETS(SETS), .WAYS(WAYS), .VPN_W(VPN_W), .PPN_W(PPN_W), .ASID_W(ASID_W)) dut (
    .clk(clk), .reset(reset),
    .LookupValid(LookupValid), .LookupVPN(LookupVPN), .LookupASID(LookupASID),
    .RespValid(RespValid), .RespHit(RespHit), .RespPPN(RespPPN), .RespPerm(RespPerm),
    .TLBWrite(TLBWrite), .WriteVPN(WriteVPN), .WriteASID(WriteASID),
    .WritePPN(WritePPN), .WritePerm(WritePerm),
    .FlushReq(FlushReq), .FlushVAValid(FlushVAValid), .FlushVPN(FlushVPN),
    .FlushASIDValid(FlushASIDValid), .FlushASID(FlushASID),
    .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_v    [SETS][WAYS];
  logic [VPN_W-1:0]  m_vpn  [SETS][WAYS];
  logic [ASID_W-1:0] m_asid [SETS][WAYS];
  logic [PPN_W-1:0]  m_ppn  [SETS][WAYS];
  logic [7:0]        m_perm [SETS][WAYS];
  longint            m_ts   [SETS][WAYS];   // last-use time; victim = tree of older halves
  longint            tick = 0;
  int                fl_rem = 0;            // flush cycles still to run
  bit                fl_va, fl_av;
  logic [VPN_W-1:0]  fl_vpn;
  logic [ASID_W-1:0] fl_asid;
  bit                e_rv = 0, e_rh = 0, started = 0;
  logic [PPN_W-1:0]  e_ppn = '0;
  logic [7:0]        e_perm = '0;

  function automatic int m_victim(input int s);
    int lo, sz, h;
    longint ml, mr;
    lo = 0; sz = WAYS;
    while (sz > 1) begin
      h = sz / 2; ml = 0; mr = 0;
      for (int i = 0; i < h; i++) begin
        if (m_ts[s][lo+i] > ml)   ml = m_ts[s][lo+i];
        if (m_ts[s][lo+h+i] > mr) mr = m_ts[s][lo+h+i];
      end
      if (ml > mr) lo = lo + h;
      sz = h;
    end
    return lo;
  endfunction

  always @(posedge clk) begin : model
    int s, ws, fs, hw, tw, vic;
    bit busy, hit;
    started = 1;
    tick++;
    if (reset) begin
      for (int a = 0; a < SETS; a++)
        for (int b = 0; b < WAYS; b++) begin m_v[a][b] = 0; m_ts[a][b] = 0; end
      fl_rem = 0; e_rv = 0; e_rh = 0; e_ppn = '0; e_perm = '0;
    end else begin
      busy = (fl_rem > 0);
      s = int'(LookupVPN % SETS);
      hit = 0; hw = 0;
      for (int w = 0; w < WAYS; w++)
        if (m_v[s][w] && m_vpn[s][w] == LookupVPN &&
            (m_asid[s][w] == LookupASID || m_perm[s][w][5])) begin hit = 1; hw = w; end
      e_rv   = LookupValid;
      e_rh   = LookupValid && hit && !busy;
      e_ppn  = e_rh ? m_ppn[s][hw]  : '0;
      e_perm = e_rh ? m_perm[s][hw] : '0;
      ws  = int'(WriteVPN % SETS);
      vic = m_victim(ws);
      if (e_rh) m_ts[s][hw] = 2*tick;
      if (TLBWrite && !busy) begin
        tw = -1;
        for (int w = 0; w < WAYS; w++)
          if (tw < 0 && m_v[ws][w] && m_vpn[ws][w] == WriteVPN &&
              (m_asid[ws][w] == WriteASID || m_perm[ws][w][5] || WritePerm[5])) tw = w;
        for (int w = 0; w < WAYS; w++) if (tw < 0 && !m_v[ws][w]) tw = w;
        if (tw < 0) tw = vic;
        m_v[ws][tw] = 1; m_vpn[ws][tw] = WriteVPN; m_asid[ws][tw] = WriteASID;
        m_ppn[ws][tw] = WritePPN; m_perm[ws][tw] = WritePerm; m_ts[ws][tw] = 2*tick + 1;
      end
      if (busy) begin
        fs = fl_va ? int'(fl_vpn % SETS) : SETS - fl_rem;
        for (int w = 0; w < WAYS; w++)
          if (m_v[fs][w] && (!fl_va || m_vpn[fs][w] == fl_vpn) &&
              (!fl_av || (!m_perm[fs][w][5] && m_asid[fs][w] == fl_asid))) m_v[fs][w] = 0;
        fl_rem--;
      end else if (FlushReq) begin
        fl_va = FlushVAValid; fl_av = FlushASIDValid; fl_vpn = FlushVPN; fl_asid = FlushASID;
        fl_rem = FlushVAValid ? 1 : SETS;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit xb, xh;
    if (started) begin
      xb = (fl_rem > 0);
      xh = e_rh && !xb;
      chk("m_resp_valid", RespValid, e_rv);
      chk("m_resp_hit",   RespHit,   xh);
      chk("m_resp_ppn",   RespPPN,   xh ? e_ppn : '0);
      chk("m_resp_perm",  RespPerm,  xh ? e_perm : '0);
      chk("m_flush_busy", FlushBusy, xb);
      chk("m_flush_done", FlushDone, fl_rem == 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    LookupValid = 0; TLBWrite = 0; FlushReq = 0; FlushVAValid = 0; FlushASIDValid = 0;
    LookupVPN = '0; LookupASID = '0; WriteVPN = '0; WriteASID = '0; WritePPN = '0;
    WritePerm = '0; FlushVPN = '0; FlushASID = '0;
  endtask

  task automatic do_write(input logic [VPN_W-1:0] v, input logic [ASID_W-1:0] a,
                          input logic [PPN_W-1:0] p, input logic [7:0] pm);
    TLBWrite = 1; WriteVPN = v; WriteASID = a; WritePPN = p; WritePerm = pm;
    @(negedge clk);
    TLBWrite = 0;
  endtask

  task automatic do_lookup(input logic [VPN_W-1:0] v, input logic [ASID_W-1:0] a);
    LookupValid = 1; LookupVPN = v; LookupASID = a;
    @(negedge clk);
    LookupValid = 0;
  endtask

  // Runs a requested flush to completion; optionally probes lookup/write during WALK.
  task automatic run_flush(input bit probe, output int nb, output int nd);
    bit seen, fin;
    nb = 0; nd = 0; seen = 0; fin = 0;
    for (int k = 0; k < 64 && !fin; k++) begin
      @(negedge clk);
      LookupValid = 0; TLBWrite = 0;
      if (FlushBusy) begin nb++; seen = 1; FlushReq = 0; end
      if (FlushDone) nd++;
      if (probe && nb == 4 && FlushBusy) begin
        chk("walk_lookup_valid", RespValid, 1);
        chk("walk_lookup_hit",   RespHit,   0);
      end
      if (probe && nb == 3 && FlushBusy) begin
        LookupValid = 1; LookupVPN = 27'h100; LookupASID = 16'd1;
        TLBWrite = 1; WriteVPN = 27'h888; WriteASID = 16'd1; WritePPN = 44'h888; WritePerm = 8'h0F;
      end
      if (seen && !FlushBusy) fin = 1;
    end
    chk("flush_completes", fin, 1);
  endtask

  initial begin : stim
    int nb, nd;
    bit got5;
    reset = 1; idle();
    repeat (3) @(negedge clk);
    chk("reset_resp_valid", RespValid, 0);
    chk("reset_resp_hit",   RespHit,   0);
    chk("reset_flush_busy", FlushBusy, 0);
    chk("reset_flush_done", FlushDone, 0);
    reset = 0;

    // basic write / lookup, ASID mismatch
    do_write(27'h12345, 16'd3, 44'hABC, 8'hCF);
    do_lookup(27'h12345, 16'd3);
    chk("basic_hit",  RespHit,  1);
    chk("basic_ppn",  RespPPN,  44'hABC);
    chk("basic_perm", RespPerm, 8'hCF);
    do_lookup(27'h12345, 16'd4);
    chk("asid_miss_hit", RespHit, 0);
    chk("asid_miss_ppn", RespPPN, 0);

    // lookup in the same cycle as the write sees old contents
    TLBWrite = 1; WriteVPN = 27'h22225; WriteASID = 16'd3; WritePPN = 44'h222; WritePerm = 8'h0F;
    LookupValid = 1; LookupVPN = 27'h22225; LookupASID = 16'd3;
    @(negedge clk);
    TLBWrite = 0; LookupValid = 0;
    chk("same_cycle_miss", RespHit, 0);
    do_lookup(27'h22225, 16'd3);
    chk("next_cycle_hit", RespPPN, 44'h222);

    // PLRU: fill set 0, re-touch way 0, then a fifth VPN evicts way 2 (0x300)
    do_write(27'h100, 16'd1, 44'h1, 8'h0F);
    do_write(27'h200, 16'd1, 44'h2, 8'h0F);
    do_write(27'h300, 16'd1, 44'h3, 8'h0F);
    do_write(27'h400, 16'd1, 44'h4, 8'h0F);
    do_lookup(27'h100, 16'd1);
    chk("plru_touch_hit", RespHit, 1);
    do_write(27'h500, 16'd1, 44'h5, 8'h0F);
    do_lookup(27'h300, 16'd1);
    chk("plru_evicted_miss", RespHit, 0);
    do_lookup(27'h100, 16'd1);
    chk("plru_retained_ppn", RespPPN, 44'h1);
    do_lookup(27'h500, 16'd1);
    chk("plru_new_ppn", RespPPN, 44'h5);
    do_lookup(27'h200, 16'd1);
    do_lookup(27'h400, 16'd1);

    // ASID flush of ASID 3 with a global ASID-3 entry; probe lookup/write mid-walk
    do_write(27'h777, 16'd3, 44'h111, 8'h2F);
    FlushReq = 1; FlushVAValid = 0; FlushASIDValid = 1; FlushASID = 16'd3;
    run_flush(1, nb, nd);
    chk("asid_flush_busy_cycles", nb, SETS);
    chk("asid_flush_done_pulses", nd, 1);
    FlushASIDValid = 0;
    do_lookup(27'h777, 16'd5);
    chk("global_kept_ppn", RespPPN, 44'h111);
    do_lookup(27'h12345, 16'd3);
    chk("nonglobal_flushed", RespHit, 0);
    do_lookup(27'h888, 16'd1);
    chk("walk_write_ignored", RespHit, 0);
    do_lookup(27'h100, 16'd1);
    chk("other_asid_kept", RespHit, 1);

    // VA flush; the target was written the cycle before the request
    do_write(27'h22225, 16'd3, 44'h222, 8'h0F);
    do_write(27'h12345, 16'd3, 44'hABC, 8'hCF);
    FlushReq = 1; FlushVAValid = 1; FlushVPN = 27'h12345; FlushASIDValid = 0;
    run_flush(0, nb, nd);
    chk("va_flush_busy_cycles", nb, 1);
    chk("va_flush_done_pulses", nd, 1);
    FlushVAValid = 0;
    do_lookup(27'h12345, 16'd3);
    chk("va_flushed_miss", RespHit, 0);
    do_lookup(27'h22225, 16'd3);
    chk("va_sibling_hit", RespHit, 1);

    // reset during the fifth WALK cycle aborts the flush without FlushDone
    FlushReq = 1; FlushVAValid = 0; FlushASIDValid = 0;
    nb = 0; got5 = 0;
    for (int k = 0; k < 20 && !got5; k++) begin
      @(negedge clk);
      if (FlushBusy) begin nb++; FlushReq = 0; end
      if (nb == 5) got5 = 1;
    end
    chk("walk_reached_cycle5", got5, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", FlushBusy, 0);
    chk("abort_done", FlushDone, 0);
    repeat (2) @(negedge clk);
    do_lookup(27'h100, 16'd1);
    chk("abort_empty_a", RespHit, 0);
    do_lookup(27'h777, 16'd5);
    chk("abort_empty_b", RespHit, 0);
    do_lookup(27'h22225, 16'd3);
    chk("abort_empty_c", RespHit, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
